// File: rtl/wt_mem_req_arbiter.sv
// wt_mem_req_arbiter
// Merges the write-through I$ and D$ memory request streams into a single
// registered valid/ready request channel and routes memory returns back to
// the originating cache by transaction ID. Per-source outstanding counters
// apply backpressure and drive the busy indication.
//
// Optional feature macro: WT_ARB_DCACHE_PRIO_EN
//   undefined : round-robin between I$ and D$ (I$ wins the first tie)
//   defined   : fixed priority, D$ wins whenever it is eligible
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   icache_data_req_i/ack_o  I$ request (held until ack) / single-cycle ack
//   icache_data_i, _tid_i    I$ request payload and ID
//   dcache_data_req_i/ack_o  D$ request (held until ack) / single-cycle ack
//   dcache_data_i, _tid_i    D$ request payload and ID
//   mem_req_*                registered outgoing request (valid/ready)
//   mem_req_src_o            0 = I$, 1 = D$
//   mem_rtrn_vld_i/tid_i/i   memory return (always accepted)
//   icache/dcache_rtrn_vld_o registered return valids, one cycle latency
//   rtrn_o                   registered return payload shared by both caches
//   busy_o                   transaction outstanding or output register full
//   err_o                    sticky: return for a source with zero outstanding
module wt_mem_req_arbiter #(
    parameter int unsigned PayloadWidth   = 128,
    parameter int unsigned RtrnWidth      = 256,
    parameter int unsigned TidWidth       = 4,
    parameter int unsigned IcacheTxId     = 0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    icache_data_req_i,
    output logic                    icache_data_ack_o,
    input  logic [PayloadWidth-1:0] icache_data_i,
    input  logic [TidWidth-1:0]     icache_tid_i,

    input  logic                    dcache_data_req_i,
    output logic                    dcache_data_ack_o,
    input  logic [PayloadWidth-1:0] dcache_data_i,
    input  logic [TidWidth-1:0]     dcache_tid_i,

    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [PayloadWidth-1:0] mem_req_data_o,
    output logic [TidWidth-1:0]     mem_req_tid_o,
    output logic                    mem_req_src_o,

    input  logic                    mem_rtrn_vld_i,
    input  logic [TidWidth-1:0]     mem_rtrn_tid_i,
    input  logic [RtrnWidth-1:0]    mem_rtrn_i,

    output logic                    icache_rtrn_vld_o,
    output logic                    dcache_rtrn_vld_o,
    output logic [RtrnWidth-1:0]    rtrn_o,

    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax    = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] CntZero   = CntWidth'(0);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
    localparam logic [TidWidth-1:0] IcacheTid = TidWidth'(IcacheTxId);

    logic [CntWidth-1:0] icache_cnt_q;
    logic [CntWidth-1:0] dcache_cnt_q;

    logic icache_elig;
    logic dcache_elig;
    logic can_load;
    logic grant_icache;
    logic grant_dcache;
    logic rtrn_to_icache;
    logic rtrn_to_dcache;
    logic err_set;

`ifndef WT_ARB_DCACHE_PRIO_EN
    // 1 = D$ was granted last, so I$ wins the next tie
    logic rr_last_dcache_q;
`endif

    // Saturating up/down counter step; simultaneous inc/dec cancels
    function automatic logic [CntWidth-1:0] cnt_next(
        input logic [CntWidth-1:0] cnt,
        input logic                inc,
        input logic                dec
    );
        logic [CntWidth-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CntOne;
        end else if (dec && !inc && (cnt != CntZero)) begin
            res = cnt - CntOne;
        end
        return res;
    endfunction

    // Arbitration and return classification
    always_comb begin
        icache_elig  = icache_data_req_i && (icache_cnt_q < CntMax);
        dcache_elig  = dcache_data_req_i && (dcache_cnt_q < CntMax);
        // Register loads when empty or when draining this very cycle
        can_load     = rst_ni && (!mem_req_valid_o || mem_req_ready_i);
        grant_icache = 1'b0;
        grant_dcache = 1'b0;
`ifdef WT_ARB_DCACHE_PRIO_EN
        grant_dcache = can_load && dcache_elig;
        grant_icache = can_load && icache_elig && !dcache_elig;
`else
        grant_icache = can_load && icache_elig && (!dcache_elig || rr_last_dcache_q);
        grant_dcache = can_load && dcache_elig && (!icache_elig || !rr_last_dcache_q);
`endif
        rtrn_to_icache = mem_rtrn_vld_i && (mem_rtrn_tid_i == IcacheTid);
        rtrn_to_dcache = mem_rtrn_vld_i && (mem_rtrn_tid_i != IcacheTid);
        err_set = (rtrn_to_icache && (icache_cnt_q == CntZero)) ||
                  (rtrn_to_dcache && (dcache_cnt_q == CntZero));
    end

    assign icache_data_ack_o = grant_icache;
    assign dcache_data_ack_o = grant_dcache;

    assign busy_o = (icache_cnt_q != CntZero) || (dcache_cnt_q != CntZero) || mem_req_valid_o;

    // Control state: valids, counters, error flag, arbitration pointer
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_req_valid_o   <= 1'b0;
            icache_cnt_q      <= CntZero;
            dcache_cnt_q      <= CntZero;
            icache_rtrn_vld_o <= 1'b0;
            dcache_rtrn_vld_o <= 1'b0;
            err_o             <= 1'b0;
`ifndef WT_ARB_DCACHE_PRIO_EN
            rr_last_dcache_q  <= 1'b1;
`endif
        end else begin
            if (grant_icache || grant_dcache) begin
                mem_req_valid_o <= 1'b1;
            end else if (mem_req_ready_i) begin
                mem_req_valid_o <= 1'b0;
            end
            icache_cnt_q      <= cnt_next(icache_cnt_q, grant_icache, rtrn_to_icache);
            dcache_cnt_q      <= cnt_next(dcache_cnt_q, grant_dcache, rtrn_to_dcache);
            icache_rtrn_vld_o <= rtrn_to_icache;
            dcache_rtrn_vld_o <= rtrn_to_dcache;
            if (err_set) begin
                err_o <= 1'b1;
            end
`ifndef WT_ARB_DCACHE_PRIO_EN
            if (grant_icache) begin
                rr_last_dcache_q <= 1'b0;
            end else if (grant_dcache) begin
                rr_last_dcache_q <= 1'b1;
            end
`endif
        end
    end

    // Datapath registers carry no reset; they are qualified by the valids
    always_ff @(posedge clk_i) begin
        if (grant_icache) begin
            mem_req_data_o <= icache_data_i;
            mem_req_tid_o  <= icache_tid_i;
            mem_req_src_o  <= 1'b0;
        end else if (grant_dcache) begin
            mem_req_data_o <= dcache_data_i;
            mem_req_tid_o  <= dcache_tid_i;
            mem_req_src_o  <= 1'b1;
        end
        if (mem_rtrn_vld_i) begin
            rtrn_o <= mem_rtrn_i;
        end
    end

`ifndef SYNTHESIS
    // A request seen without ack must still be present next cycle
    logic icache_wait_q;
    logic dcache_wait_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            icache_wait_q <= 1'b0;
            dcache_wait_q <= 1'b0;
        end else begin
            a_icache_req_hold: assert (!(icache_wait_q && !icache_data_req_i))
                else $error("icache request dropped before ack");
            a_dcache_req_hold: assert (!(dcache_wait_q && !dcache_data_req_i))
                else $error("dcache request dropped before ack");
            icache_wait_q <= icache_data_req_i && !icache_data_ack_o;
            dcache_wait_q <= dcache_data_req_i && !dcache_data_ack_o;
        end
    end
`endif

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed, table-driven bench for wt_mem_req_arbiter (default round-robin build).
// Each table row is one clock cycle: inputs are driven just after the rising
// edge, and outputs are compared at the falling edge. Registered outputs in a
// row reflect the state produced by earlier rows; acks reflect the row's inputs.
module tb_wt_mem_req_arbiter;

    localparam int unsigned PW = 128;
    localparam int unsigned RW = 256;
    localparam int unsigned TW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          icache_data_req_i;
    logic          icache_data_ack_o;
    logic [PW-1:0] icache_data_i;
    logic [TW-1:0] icache_tid_i;
    logic          dcache_data_req_i;
    logic          dcache_data_ack_o;
    logic [PW-1:0] dcache_data_i;
    logic [TW-1:0] dcache_tid_i;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [PW-1:0] mem_req_data_o;
    logic [TW-1:0] mem_req_tid_o;
    logic          mem_req_src_o;
    logic          mem_rtrn_vld_i;
    logic [TW-1:0] mem_rtrn_tid_i;
    logic [RW-1:0] mem_rtrn_i;
    logic          icache_rtrn_vld_o;
    logic          dcache_rtrn_vld_o;
    logic [RW-1:0] rtrn_o;
    logic          busy_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    wt_mem_req_arbiter dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .icache_data_req_i (icache_data_req_i),
        .icache_data_ack_o (icache_data_ack_o),
        .icache_data_i     (icache_data_i),
        .icache_tid_i      (icache_tid_i),
        .dcache_data_req_i (dcache_data_req_i),
        .dcache_data_ack_o (dcache_data_ack_o),
        .dcache_data_i     (dcache_data_i),
        .dcache_tid_i      (dcache_tid_i),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_req_data_o    (mem_req_data_o),
        .mem_req_tid_o     (mem_req_tid_o),
        .mem_req_src_o     (mem_req_src_o),
        .mem_rtrn_vld_i    (mem_rtrn_vld_i),
        .mem_rtrn_tid_i    (mem_rtrn_tid_i),
        .mem_rtrn_i        (mem_rtrn_i),
        .icache_rtrn_vld_o (icache_rtrn_vld_o),
        .dcache_rtrn_vld_o (dcache_rtrn_vld_o),
        .rtrn_o            (rtrn_o),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    typedef struct {
        logic       rst_n;
        logic       ireq;
        logic [7:0] idat;
        logic       dreq;
        logic [3:0] dtid;
        logic [7:0] ddat;
        logic       rdy;
        logic       rv;
        logic [3:0] rtid;
        logic [7:0] rdat;
        logic       e_ia;
        logic       e_da;
        logic       e_v;
        logic       e_src;
        logic [3:0] e_tid;
        logic [7:0] e_dat;
        logic       e_irv;
        logic       e_drv;
        logic [7:0] e_rtrn;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(
        input logic rst_n, input logic ireq, input logic [7:0] idat,
        input logic dreq, input logic [3:0] dtid, input logic [7:0] ddat,
        input logic rdy, input logic rv, input logic [3:0] rtid, input logic [7:0] rdat,
        input logic e_ia, input logic e_da, input logic e_v, input logic e_src,
        input logic [3:0] e_tid, input logic [7:0] e_dat,
        input logic e_irv, input logic e_drv, input logic [7:0] e_rtrn,
        input logic e_busy, input logic e_err
    );
        vec_t v;
        v.rst_n = rst_n; v.ireq = ireq; v.idat = idat;
        v.dreq = dreq; v.dtid = dtid; v.ddat = ddat;
        v.rdy = rdy; v.rv = rv; v.rtid = rtid; v.rdat = rdat;
        v.e_ia = e_ia; v.e_da = e_da; v.e_v = e_v; v.e_src = e_src;
        v.e_tid = e_tid; v.e_dat = e_dat;
        v.e_irv = e_irv; v.e_drv = e_drv; v.e_rtrn = e_rtrn;
        v.e_busy = e_busy; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [255:0] act,
                       input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_ni            = v.rst_n;
        icache_data_req_i = v.ireq;
        icache_data_i     = PW'(v.idat);
        icache_tid_i      = '0;
        dcache_data_req_i = v.dreq;
        dcache_tid_i      = v.dtid;
        dcache_data_i     = PW'(v.ddat);
        mem_req_ready_i   = v.rdy;
        mem_rtrn_vld_i    = v.rv;
        mem_rtrn_tid_i    = v.rtid;
        mem_rtrn_i        = RW'(v.rdat);
    endtask

    initial begin
        //  rst ir idat  dr tid ddat rdy rv rtid rdat | ia da v src tid dat  irv drv rtrn busy err
        // single I$ request and its return
        add(0, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0);
        add(1, 1, 'hA5, 0, 0, 'h00, 1, 0, 0, 'h00,   1, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 1, 0, 0, 'hA5, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 1, 0, 'h3C,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 1, 0, 'h3C, 0, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0);
        // round-robin from reset with both caches requesting
        add(0, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0);
        add(1, 1, 'h11, 1, 5, 'h22, 1, 0, 0, 'h00,   1, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0);
        add(1, 1, 'h12, 1, 5, 'h22, 1, 0, 0, 'h00,   0, 1, 1, 0, 0, 'h11, 0, 0, 'h00, 1, 0);
        add(1, 1, 'h13, 1, 6, 'h23, 1, 0, 0, 'h00,   1, 0, 1, 1, 5, 'h22, 0, 0, 'h00, 1, 0);
        add(1, 1, 'h14, 1, 6, 'h23, 1, 0, 0, 'h00,   0, 1, 1, 0, 0, 'h13, 0, 0, 'h00, 1, 0);
        add(1, 1, 'h14, 0, 0, 'h00, 1, 0, 0, 'h00,   1, 0, 1, 1, 6, 'h23, 0, 0, 'h00, 1, 0);
        // D$ fills to four outstanding, fifth blocked until a return
        add(1, 0, 'h00, 1, 7, 'h31, 1, 0, 0, 'h00,   0, 1, 1, 0, 0, 'h14, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 1, 8, 'h32, 1, 0, 0, 'h00,   0, 1, 1, 1, 7, 'h31, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 1, 9, 'h33, 1, 0, 0, 'h00,   0, 0, 1, 1, 8, 'h32, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 1, 9, 'h33, 1, 1, 3, 'h77,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 1, 9, 'h33, 1, 0, 0, 'h00,   0, 1, 0, 0, 0, 'h00, 0, 1, 'h77, 1, 0);
        // ready low for five cycles with a request registered
        for (int i = 0; i < 5; i++)
            add(1, 1, 'h41, 0, 0, 'h00, 0, 0, 0, 'h00, 0, 0, 1, 1, 9, 'h33, 0, 0, 'h00, 1, 0);
        add(1, 1, 'h41, 0, 0, 'h00, 1, 0, 0, 'h00,   1, 0, 1, 1, 9, 'h33, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 1, 0, 0, 'h41, 0, 0, 'h00, 1, 0);
        // return coinciding with a D$ ack leaves the D$ count unchanged
        add(1, 0, 'h00, 0, 0, 'h00, 1, 1, 4, 'h66,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 1,10, 'h51, 1, 1, 2, 'h5A,   0, 1, 0, 0, 0, 'h00, 0, 1, 'h66, 1, 0);
        add(1, 0, 'h00, 1,11, 'h52, 1, 0, 0, 'h00,   0, 1, 1, 1,10, 'h51, 0, 1, 'h5A, 1, 0);
        add(1, 0, 'h00, 1,12, 'h53, 1, 0, 0, 'h00,   0, 0, 1, 1,11, 'h52, 0, 0, 'h00, 1, 0);
        // reset mid-flight, then an unexpected I$ return raises sticky err
        add(0, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 1, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 1, 0, 'h99,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 1, 0, 'h99, 0, 1);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 1);
        add(0, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 1);
        add(1, 0, 'h00, 0, 0, 'h00, 1, 0, 0, 'h00,   0, 0, 0, 0, 0, 'h00, 0, 0, 'h00, 0, 0);

        // Initial reset
        rst_ni = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk_i);

        foreach (vecs[i]) begin
            @(posedge clk_i);
            #1;
            drive(vecs[i]);
            @(negedge clk_i);
            chk("icache_ack", i, 256'(icache_data_ack_o), 256'(vecs[i].e_ia));
            chk("dcache_ack", i, 256'(dcache_data_ack_o), 256'(vecs[i].e_da));
            chk("req_valid",  i, 256'(mem_req_valid_o),   256'(vecs[i].e_v));
            if (vecs[i].e_v) begin
                chk("req_src",  i, 256'(mem_req_src_o),  256'(vecs[i].e_src));
                chk("req_tid",  i, 256'(mem_req_tid_o),  256'(vecs[i].e_tid));
                chk("req_data", i, 256'(mem_req_data_o), 256'(vecs[i].e_dat));
            end
            chk("icache_rtrn_vld", i, 256'(icache_rtrn_vld_o), 256'(vecs[i].e_irv));
            chk("dcache_rtrn_vld", i, 256'(dcache_rtrn_vld_o), 256'(vecs[i].e_drv));
            if (vecs[i].e_irv || vecs[i].e_drv)
                chk("rtrn_data", i, 256'(rtrn_o), 256'(vecs[i].e_rtrn));
            chk("busy", i, 256'(busy_o), 256'(vecs[i].e_busy));
            chk("err",  i, 256'(err_o),  256'(vecs[i].e_err));
        end

        // Hand sequence: D$ request into an empty register with ready low,
        // then an I$ request stalls until ready returns.
        begin
            int waited;
            @(posedge clk_i);
            #1;
            dcache_data_req_i = 1'b1;
            dcache_tid_i      = 4'd13;
            dcache_data_i     = PW'(8'hE1);
            mem_req_ready_i   = 1'b0;
            waited = 0;
            @(negedge clk_i);
            while (!dcache_data_ack_o && waited < 8) begin
                @(negedge clk_i);
                waited++;
            end
            chk("hs_dack_wait", 0, 256'(dcache_data_ack_o), 256'(1));
            @(posedge clk_i);
            #1;
            dcache_data_req_i = 1'b0;
            icache_data_req_i = 1'b1;
            icache_data_i     = PW'(8'hF2);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk_i);
                chk("hs_stall_iack",  k, 256'(icache_data_ack_o), 256'(0));
                chk("hs_stall_valid", k, 256'(mem_req_valid_o),   256'(1));
                chk("hs_stall_tid",   k, 256'(mem_req_tid_o),     256'(13));
                chk("hs_stall_data",  k, 256'(mem_req_data_o),    256'(8'hE1));
                @(posedge clk_i);
                #1;
            end
            mem_req_ready_i = 1'b1;
            @(negedge clk_i);
            chk("hs_release_iack", 0, 256'(icache_data_ack_o), 256'(1));
            @(posedge clk_i);
            #1;
            icache_data_req_i = 1'b0;
            @(negedge clk_i);
            chk("hs_reload_src",  0, 256'(mem_req_src_o),  256'(0));
            chk("hs_reload_data", 0, 256'(mem_req_data_o), 256'(8'hF2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Sits directly downstream of the write-through I$/D$ memory request ports and upstream of the memory adapter.
- Merges the I$ and D$ miss/write request streams into one registered valid/ready request channel, using round-robin arbitration.
- Routes memory returns back to the originating cache by transaction ID.
- Tracks outstanding transactions per source, applies per-source backpressure, and produces a busy indication for the cache subsystem.

Parameters:
- PayloadWidth, 128, width of the request payload (address, size, wdata, type), opaque to this block.
- RtrnWidth, 256, width of the return payload, opaque to this block.
- TidWidth, 4, transaction ID width.
- IcacheTxId, 0, the ID reserved for I$ reads. Every other ID belongs to the D$.
- MaxOutstanding, 4, maximum in-flight transactions per source (1..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- icache_data_req_i  in  1  I$ request, held until acked
- icache_data_ack_o  out  1  single-cycle ack to I$
- icache_data_i  in  PayloadWidth  I$ request payload
- icache_tid_i  in  TidWidth  I$ request ID
- dcache_data_req_i  in  1  D$ request, held until acked
- dcache_data_ack_o  out  1  single-cycle ack to D$
- dcache_data_i  in  PayloadWidth  D$ request payload
- dcache_tid_i  in  TidWidth  D$ request ID
- mem_req_valid_o  out  1  outgoing request valid
- mem_req_ready_i  in  1  adapter ready
- mem_req_data_o  out  PayloadWidth  outgoing payload
- mem_req_tid_o  out  TidWidth  outgoing ID
- mem_req_src_o  out  1  0 = I$, 1 = D$
- mem_rtrn_vld_i  in  1  return valid (always accepted)
- mem_rtrn_tid_i  in  TidWidth  return ID
- mem_rtrn_i  in  RtrnWidth  return payload
- icache_rtrn_vld_o  out  1  return valid to I$
- dcache_rtrn_vld_o  out  1  return valid to D$
- rtrn_o  out  RtrnWidth  registered return payload, shared by both caches
- busy_o  out  1  any transaction outstanding, or output register full
- err_o  out  1  sticky: a return arrived for a source with zero outstanding

Behaviour:
- Reset (synchronous, rst_ni low at clk edge):
  - All valids, acks, busy_o and err_o are 0.
  - Counters are 0.
  - RR pointer is "D$ last granted", so I$ wins the first tie.
  - Payload registers are don't-care.
  - Reset mid-transaction discards the registered request and all counts. Returns after reset are routed normally but raise err_o.
- Output register, one entry:
  - It may load when it is empty, or when mem_req_valid_o and mem_req_ready_i are both high in the same cycle (back-to-back, full throughput).
  - Payload, tid and src are stable while valid is high and ready is low.
- Eligibility: a source is eligible when its req is high and its counter < MaxOutstanding.
- Arbitration:
  - Only one eligible source: it wins.
  - Both eligible: the source not last granted wins, and the pointer updates to the winner.
  - Grant occurs only when the register can load.
  - The winner's ack is high that same cycle. The register holds the request from the next cycle.
  - Request-to-mem_req_valid_o latency is 1 cycle.
- Counters:
  - A source's counter increments on its ack and decrements on a return routed to it.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - Counter width is $clog2(MaxOutstanding+1).
  - A decrement at 0 saturates at 0 and sets err_o.
- Return routing:
  - mem_rtrn_tid_i == IcacheTxId goes to I$; any other ID goes to D$.
  - Return is registered with 1-cycle latency: {icache,dcache}_rtrn_vld_o pulse one cycle after mem_rtrn_vld_i, with rtrn_o captured.
  - Exactly one of the two return valids is high per return.
- busy_o = (icache count ≠ 0) | (dcache count ≠ 0) | mem_req_valid_o, taken combinationally from registers.
- Deassertion of a req before its ack is illegal; it is flagged by a simulation-only assertion.

Optional Feature:
- Macro: WT_ARB_DCACHE_PRIO_EN.
- Defined: fixed priority replaces RR. D$ wins whenever it is eligible, the RR pointer is removed, and I$ is granted only when D$ is not eligible. This lowers store-drain latency at the cost of fetch fairness.
- Undefined: round-robin as described above.

Test Plan:
- Single I$ request, tid 0, payload 0xA5, with ready=1 → ack at cycle 0, then mem_req_valid_o at cycle 1 with src 0, tid 0, data 0xA5; busy_o=1 until the tid 0 return, after which icache_rtrn_vld_o pulses one cycle later.
- Both caches requesting continuously with ready=1 → grants alternate I$, D$, I$, D$ from reset, with one mem request every cycle. With WT_ARB_DCACHE_PRIO_EN defined, every grant goes to D$ until it reaches 4 outstanding, then I$ is granted.
- D$ issues 4 requests with no returns → 5th request is not acked. A return with tid 3 frees a slot → ack follows on the next cycle.
- ready held 0 for 5 cycles with a request registered → mem_req_* stable, no further acks. ready rises → handshake, and the register reloads in the same cycle.
- Return tid 2 arriving on the same cycle as a D$ ack → D$ counter unchanged; dcache_rtrn_vld_o pulses with rtrn_o equal to the input payload.
- Return tid 0 with the I$ counter at 0 → err_o set and held until reset; the count stays 0.
